// File: rtl/zeroheti_pkg.sv
// Shared definitions for the APB machine timer.
// Register offsets (word index) and CTRL layout.
package zeroheti_pkg;

    localparam logic [2:0] OFF_MTIME_LO    = 3'd0;
    localparam logic [2:0] OFF_MTIME_HI    = 3'd1;
    localparam logic [2:0] OFF_MTIMECMP_LO = 3'd2;
    localparam logic [2:0] OFF_MTIMECMP_HI = 3'd3;
    localparam logic [2:0] OFF_CTRL        = 3'd4;
    localparam logic [2:0] OFF_STATUS      = 3'd5;

    // CTRL: [31:8] presc, [7:2] reserved, [1] irq_en, [0] en
    typedef struct packed {
        logic [23:0] presc;
        logic [5:0]  rsvd;
        logic        irq_en;
        logic        en;
    } ctrl_t;

    // Unmapped offsets and writes to the read-only STATUS word fault.
    function automatic logic access_err(
        input logic [2:0] off,
        input logic       wr
    );
        return (off > OFF_STATUS) || (wr && off == OFF_STATUS);
    endfunction

endpackage

// File: rtl/apb_mtimer_presc.sv
// Prescaler for the machine timer.
// Emits a one-cycle tick every presc_i+1 enabled cycles.
module apb_mtimer_presc #(
    parameter int unsigned PrescWidth = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  en_i,
    input  logic                  clr_i,
    input  logic [PrescWidth-1:0] presc_i,
    output logic                  tick_o
);

    logic [PrescWidth-1:0] cnt_q;

    assign tick_o = en_i && (cnt_q == presc_i);

    // Count enabled cycles; restart on wrap, disable or CTRL write.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (!en_i || clr_i || tick_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + PrescWidth'(1);
        end
    end

endmodule

// File: rtl/apb_mtimer.sv
// APB machine timer: 64-bit mtime/mtimecmp with prescaler,
// coherent LO/HI read via shadow, level interrupt.
module apb_mtimer
    import zeroheti_pkg::*;
#(
    parameter int unsigned AddrWidth  = 32,
    parameter int unsigned DataWidth  = 32,
    parameter int unsigned PrescWidth = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 psel_i,
    input  logic                 penable_i,
    input  logic                 pwrite_i,
    input  logic [AddrWidth-1:0] paddr_i,
    input  logic [DataWidth-1:0] pwdata_i,
    output logic [DataWidth-1:0] prdata_o,
    output logic                 pready_o,
    output logic                 pslverr_o,
    output logic                 timer_irq_o
);

    logic [63:0] mtime_q;
    logic [63:0] mtimecmp_q;
    logic [31:0] shadow_q;
    ctrl_t       ctrl_q;
    logic        irq_q;

    logic       access;
    logic       err;
    logic       wr_ok;
    logic       rd_ok;
    logic [2:0] off;
    logic       we_mlo;
    logic       we_mhi;
    logic       we_clo;
    logic       we_chi;
    logic       we_ctrl;
    logic       pending;
    logic       tick;
    logic       unused_paddr;

    assign off    = paddr_i[4:2];
    assign access = psel_i & penable_i;
    assign err    = access & access_err(off, pwrite_i);
    assign wr_ok  = access & pwrite_i & ~err;
    assign rd_ok  = access & ~pwrite_i & ~err;

    assign we_mlo  = wr_ok & (off == OFF_MTIME_LO);
    assign we_mhi  = wr_ok & (off == OFF_MTIME_HI);
    assign we_clo  = wr_ok & (off == OFF_MTIMECMP_LO);
    assign we_chi  = wr_ok & (off == OFF_MTIMECMP_HI);
    assign we_ctrl = wr_ok & (off == OFF_CTRL);

    assign pending     = (mtime_q >= mtimecmp_q);
    assign pready_o    = access;
    assign pslverr_o   = err;
    assign timer_irq_o = irq_q;

    assign unused_paddr = ^{paddr_i[AddrWidth-1:5], paddr_i[1:0]};

    apb_mtimer_presc #(
        .PrescWidth (PrescWidth)
    ) u_presc (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .en_i    (ctrl_q.en),
        .clr_i   (we_ctrl),
        .presc_i (ctrl_q.presc[PrescWidth-1:0]),
        .tick_o  (tick)
    );

    // Read mux; non-read cycles and faulting reads return zero.
    always_comb begin
        prdata_o = '0;
        if (rd_ok) begin
            case (off)
                OFF_MTIME_LO:    prdata_o = mtime_q[31:0];
                OFF_MTIME_HI:    prdata_o = shadow_q;
                OFF_MTIMECMP_LO: prdata_o = mtimecmp_q[31:0];
                OFF_MTIMECMP_HI: prdata_o = mtimecmp_q[63:32];
                OFF_CTRL:        prdata_o = ctrl_q;
                OFF_STATUS:      prdata_o = {31'b0, pending};
                default:         prdata_o = '0;
            endcase
        end
    end

    // mtime: a software write beats the tick in the same cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mtime_q <= '0;
        end else if (we_mlo) begin
            mtime_q[31:0] <= pwdata_i;
        end else if (we_mhi) begin
            mtime_q[63:32] <= pwdata_i;
        end else if (tick) begin
            mtime_q <= mtime_q + 64'd1;
        end
    end

    // Shadow holds the high word seen by the last LO read.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            shadow_q <= '0;
        end else if (rd_ok && off == OFF_MTIME_LO) begin
            shadow_q <= mtime_q[63:32];
        end else if (we_mhi) begin
            shadow_q <= pwdata_i;
        end
    end

    // Compare value and control register writes.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mtimecmp_q <= '1;
            ctrl_q     <= '0;
        end else begin
            if (we_clo) mtimecmp_q[31:0]  <= pwdata_i;
            if (we_chi) mtimecmp_q[63:32] <= pwdata_i;
            if (we_ctrl) begin
                ctrl_q.presc  <= 24'(pwdata_i[8 +: PrescWidth]);
                ctrl_q.rsvd   <= '0;
                ctrl_q.irq_en <= pwdata_i[1];
                ctrl_q.en     <= pwdata_i[0];
            end
        end
    end

    // Registered level interrupt from the current compare.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= pending & ctrl_q.irq_en;
        end
    end

endmodule

// File: tb/tb_apb_mtimer.sv
// Self-checking bench for apb_mtimer.
// Time-based reference model of mtime, shadow and interrupt.
module tb_apb_mtimer;

    localparam logic [31:0] BASE = 32'h0200_4000;
    localparam logic [31:0] A_MLO  = BASE | 32'h00;
    localparam logic [31:0] A_MHI  = BASE | 32'h04;
    localparam logic [31:0] A_CLO  = BASE | 32'h08;
    localparam logic [31:0] A_CHI  = BASE | 32'h0C;
    localparam logic [31:0] A_CTRL = BASE | 32'h10;
    localparam logic [31:0] A_STAT = BASE | 32'h14;
    localparam logic [31:0] A_U6   = BASE | 32'h18;
    localparam logic [31:0] A_U7   = BASE | 32'h1C;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        irq;

    int cyc = 0;
    int ncomp = 0;
    int nfail = 0;

    // reference model state
    logic [63:0] m_base;
    logic [63:0] m_cmp;
    logic [31:0] m_shadow;
    int          m_k;
    int          m_p;
    bit          m_en;
    bit          m_ie;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    apb_mtimer dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .psel_i      (psel),
        .penable_i   (penable),
        .pwrite_i    (pwrite),
        .paddr_i     (paddr),
        .pwdata_i    (pwdata),
        .prdata_o    (prdata),
        .pready_o    (pready),
        .pslverr_o   (pslverr),
        .timer_irq_o (irq)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    // mtime after posedge number c: one tick per (presc+1) enabled cycles
    function automatic logic [63:0] m_at(input int c);
        if (!m_en || c <= m_k) return m_base;
        return m_base + 64'((c - m_k) / (m_p + 1));
    endfunction

    function automatic logic exp_irq(input int c);
        if (c - 1 < m_k) return 1'b0;
        return m_ie && (m_at(c - 1) >= m_cmp);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input bit wr, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output logic err, output int acc);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = wr;
        paddr = addr; pwdata = wd;
        #1;
        check("pready_setup", 64'(pready), 64'd0);
        check("prdata_setup", 64'(prdata), 64'd0);
        @(negedge clk);
        penable = 1'b1;
        #1;
        check("pready_access", 64'(pready), 64'd1);
        if (wr) check("prdata_on_write", 64'(prdata), 64'd0);
        rd = prdata; err = pslverr; acc = cyc;
        @(posedge clk);
        #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic wr_reg(input logic [31:0] addr, input logic [31:0] d,
                          output int commit);
        logic [31:0] rd;
        logic        err;
        int          acc;
        xfer(1'b1, addr, d, rd, err, acc);
        check("wr_slverr", 64'(err), 64'd0);
        commit = acc + 1;
    endtask

    task automatic rd_reg(input logic [31:0] addr, output logic [31:0] d,
                          output int acc);
        logic err;
        xfer(1'b0, addr, 32'h0, d, err, acc);
        check("rd_slverr", 64'(err), 64'd0);
    endtask

    task automatic set_ctrl(input bit en, input bit ie, input int p);
        int k;
        wr_reg(A_CTRL, (32'(p) << 8) | (32'(ie) << 1) | 32'(en), k);
        m_k = k; m_en = en; m_ie = ie; m_p = p;
    endtask

    // only used while the timer is disabled
    task automatic set_mtime(input logic [63:0] v);
        int k;
        wr_reg(A_MHI, v[63:32], k);
        wr_reg(A_MLO, v[31:0], k);
        m_base = v;
        m_shadow = v[63:32];
    endtask

    task automatic set_cmp(input logic [63:0] v);
        int k;
        wr_reg(A_CHI, v[63:32], k);
        wr_reg(A_CLO, v[31:0], k);
        m_cmp = v;
    endtask

    task automatic read_pair(input string tag);
        logic [31:0] lo;
        logic [31:0] hi;
        logic [63:0] e;
        int          acc;
        rd_reg(A_MLO, lo, acc);
        e = m_at(acc);
        m_shadow = e[63:32];
        rd_reg(A_MHI, hi, acc);
        check(tag, {hi, lo}, e);
    endtask

    task automatic irq_cycles(input int n, input string tag);
        repeat (n) begin
            @(negedge clk);
            #1;
            check(tag, 64'(irq), 64'(exp_irq(cyc)));
        end
    endtask

    task automatic model_reset();
        m_base = '0; m_cmp = '1; m_shadow = '0;
        m_k = 0; m_p = 0; m_en = 1'b0; m_ie = 1'b0;
    endtask

    task automatic check_reset_regs(input string tag);
        logic [31:0] d;
        int          acc;
        rd_reg(A_MLO, d, acc);
        check({tag, "_mlo"}, 64'(d), 64'd0);
        rd_reg(A_MHI, d, acc);
        check({tag, "_mhi"}, 64'(d), 64'd0);
        rd_reg(A_CLO, d, acc);
        check({tag, "_clo"}, 64'(d), 64'hFFFF_FFFF);
        rd_reg(A_CHI, d, acc);
        check({tag, "_chi"}, 64'(d), 64'hFFFF_FFFF);
        rd_reg(A_CTRL, d, acc);
        check({tag, "_ctrl"}, 64'(d), 64'd0);
        rd_reg(A_STAT, d, acc);
        check({tag, "_stat"}, 64'(d), 64'd0);
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] d2;
        logic        err;
        int          acc;
        int          k;
        logic [63:0] v;
        int          p;
        bit          ie;

        rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_irq", 64'(irq), 64'd0);
        check_reset_regs("reset");

        // free-running count at PRESC 0
        set_ctrl(1'b1, 1'b0, 0);
        repeat (10) @(negedge clk);
        xfer(1'b0, A_MLO, 32'h0, d, err, acc);
        check("count10_lo", 64'(d), m_at(acc));
        check("count10_slverr", 64'(err), 64'd0);

        // PRESC 3: one tick per four cycles
        set_ctrl(1'b0, 1'b0, 0);
        set_mtime(64'd0);
        set_ctrl(1'b1, 1'b0, 3);
        for (int i = 0; i < 5; i++) begin
            repeat (i) @(negedge clk);
            rd_reg(A_MLO, d, acc);
            check("presc3_lo", 64'(d), m_at(acc));
        end
        rd_reg(A_CTRL, d, acc);
        check("presc3_ctrl", 64'(d), 64'h301);

        // LO/HI read pair across the 32-bit carry
        set_ctrl(1'b0, 1'b0, 0);
        set_mtime(64'h0000_0000_FFFF_FFFE);
        set_ctrl(1'b1, 1'b0, 0);
        read_pair("carry_pair_a");
        read_pair("carry_pair_b");

        // interrupt rise and clear
        set_ctrl(1'b0, 1'b0, 0);
        set_mtime(64'd0);
        set_cmp(64'd20);
        set_ctrl(1'b1, 1'b1, 0);
        irq_cycles(28, "irq_rise");
        wr_reg(A_CLO, 32'd100, k);
        m_cmp = 64'd100;
        @(negedge clk);
        #1;
        check("irq_hold_on_write", 64'(irq), 64'd1);
        @(negedge clk);
        #1;
        check("irq_cleared", 64'(irq), 64'd0);

        // error responses leave state unchanged
        rd_reg(A_CTRL, d2, acc);
        xfer(1'b0, A_U6, 32'h0, d, err, acc);
        check("u6_rd_slverr", 64'(err), 64'd1);
        check("u6_rd_data", 64'(d), 64'd0);
        xfer(1'b0, A_U7, 32'h0, d, err, acc);
        check("u7_rd_slverr", 64'(err), 64'd1);
        check("u7_rd_data", 64'(d), 64'd0);
        xfer(1'b1, A_STAT, 32'hFFFF_FFFF, d, err, acc);
        check("stat_wr_slverr", 64'(err), 64'd1);
        xfer(1'b1, A_U6, 32'hFFFF_FFFF, d, err, acc);
        check("u6_wr_slverr", 64'(err), 64'd1);
        rd_reg(A_CTRL, d, acc);
        check("err_ctrl_kept", 64'(d), 64'(d2));
        rd_reg(A_CLO, d, acc);
        check("err_cmp_kept", 64'(d), 64'd100);

        // reset mid-count with interrupt high; write during reset dropped
        wr_reg(A_CLO, 32'd20, k);
        m_cmp = 64'd20;
        repeat (2) @(negedge clk);
        #1;
        check("irq_before_reset", 64'(irq), 64'd1);
        rst_n = 1'b0;
        xfer(1'b1, A_MLO, 32'h55, d, err, acc);
        check("reset_wr_slverr", 64'(err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        #1;
        check("post_reset_irq", 64'(irq), 64'd0);
        check_reset_regs("post_reset");

        // randomized runs against the model
        for (int it = 0; it < 12; it++) begin
            set_ctrl(1'b0, 1'b0, 0);
            v = {$urandom, $urandom};
            if (it % 2 == 1) v[31:0] = 32'hFFFF_FFFF - $urandom_range(0, 6);
            set_mtime(v);
            set_cmp(v + 64'($urandom_range(0, 30)));
            p = $urandom_range(0, 5);
            ie = 1'($urandom_range(0, 1));
            set_ctrl(1'b1, ie, p);
            irq_cycles($urandom_range(2, 30), "rnd_irq");
            read_pair("rnd_pair");
            rd_reg(A_STAT, d, acc);
            check("rnd_status", 64'(d), 64'(m_at(acc) >= m_cmp));
            rd_reg(A_CTRL, d, acc);
            check("rnd_ctrl", 64'(d),
                  64'((p << 8) | (int'(ie) << 1) | 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncomp, nfail);
        $finish;
    end

endmodule
